// File: rtl/card_deck_shuffler.sv
// Builds a game deck: fills the colour table with matching pairs, then
// shuffles it in place (Fisher-Yates driven by a free-running LFSR).
module card_deck_shuffler #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_W      = 6,
    parameter int unsigned COLOR_W    = 12,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter bit          SHUFFLE_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_W-1:0]   num_of_cards,
    output logic               done,
    output logic               busy,
    input  logic [ADDR_W-1:0]  rd_addr_a,
    output logic [COLOR_W-1:0] rd_color_a,
    input  logic [ADDR_W-1:0]  rd_addr_b,
    output logic [COLOR_W-1:0] rd_color_b
);

    localparam int unsigned MAX_CARDS = 1 << ADDR_W;
    localparam int unsigned CNT_W     = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_SHUFFLE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_i;
    logic [CNT_W-1:0]    r_n;
    logic [15:0]         r_lfsr;
    logic                r_done;
    logic                r_busy;
    logic [COLOR_W-1:0]  r_table [MAX_CARDS];

    logic [CNT_W-1:0]    w_n_eff;
    logic [ADDR_W-1:0]   w_mask;
    logic [ADDR_W-1:0]   w_j;
    logic                w_accept;
    logic                w_fill_last;
    logic                w_fill_we;
    logic                w_swap_en;
    logic [COLOR_W-1:0]  w_fill_data;
    logic                w_lfsr_fb;

    // Pair colour for a table slot: slots 2k and 2k+1 share palette[k].
    function automatic logic [COLOR_W-1:0] palette(input logic [ADDR_W-1:0] addr);
        logic [3:0] k;
        k = 4'(addr >> 1);
        return COLOR_W'({k, ~k, 4'hA});
    endfunction

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Deck size clipped to the table and rounded down to whole pairs.
    always_comb begin
        if (32'(num_of_cards) > MAX_CARDS) begin
            w_n_eff = CNT_W'(MAX_CARDS);
        end else begin
            w_n_eff = CNT_W'(num_of_cards);
        end
        w_n_eff = w_n_eff & ~CNT_W'(1);
    end

    // Smear i's top set bit downwards to get the smallest 2^m-1 >= i.
    always_comb begin
        w_mask = r_i;
        for (int unsigned s = 1; s < ADDR_W; s++) begin
            w_mask = w_mask | (r_i >> s);
        end
    end

    assign w_j         = r_lfsr[ADDR_W-1:0] & w_mask;
    assign w_accept    = (w_j <= r_i);
    assign w_fill_last = (r_i == ADDR_W'(MAX_CARDS - 1));
    assign w_fill_data = ({1'b0, r_i} < r_n) ? palette(r_i) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fill_we    = 1'b0;
        w_swap_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                w_fill_we = 1'b1;
                if (w_fill_last) begin
                    w_state_next = (SHUFFLE_EN && (r_n >= CNT_W'(4))) ? S_SHUFFLE : S_DONE;
                end
            end
            S_SHUFFLE: begin
                w_swap_en = w_accept;
                if (w_accept && (r_i == ADDR_W'(1))) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Counter, sampled deck size, LFSR and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i    <= '0;
            r_n    <= '0;
            r_lfsr <= LFSR_SEED;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            r_done <= (w_state_next == S_DONE);
            r_busy <= (w_state_next == S_FILL) || (w_state_next == S_SHUFFLE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i <= '0;
                        r_n <= w_n_eff;
                    end
                end
                S_FILL: begin
                    if (w_fill_last) begin
                        r_i <= ADDR_W'(r_n - CNT_W'(1));
                    end else begin
                        r_i <= r_i + ADDR_W'(1);
                    end
                end
                S_SHUFFLE: begin
                    if (w_accept) begin
                        r_i <= r_i - ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Colour table: one fill write or one swap per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned a = 0; a < MAX_CARDS; a++) begin
                r_table[a] <= '0;
            end
        end else if (w_fill_we) begin
            r_table[r_i] <= w_fill_data;
        end else if (w_swap_en) begin
            r_table[r_i] <= r_table[w_j];
            r_table[w_j] <= r_table[r_i];
        end
    end

    assign done       = r_done;
    assign busy       = r_busy;
    assign rd_color_a = r_table[rd_addr_a];
    assign rd_color_b = r_table[rd_addr_b];

endmodule
